// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM:SS time-keeping controller.
package clock_pkg;

    localparam int TW         = 7;
    localparam int H_MOD_DEF  = 24;
    localparam int M_MOD_DEF  = 60;
    localparam int S_MOD_DEF  = 60;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } state_t;

    // Modular increment of a time field; wraps to zero at modulus-1.
    function automatic logic [TW-1:0] wrap_inc(input logic [TW-1:0] v, input int modulus);
        return (int'(v) == modulus - 1) ? '0 : v + TW'(1);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser plus rising-edge detect; one-cycle pulse per press.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic ev
);
    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Pulse is valid between the 2nd and 3rd edge, so consumers update on the 3rd.
    assign ev = s2 & ~s3;

endmodule

// File: rtl/clock_set_ctrl.sv
// HH:MM:SS time registers, RUN/SET_H/SET_M set-mode sequencer and field blink control.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int H_MOD = H_MOD_DEF,
    parameter int M_MOD = M_MOD_DEF,
    parameter int S_MOD = S_MOD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sec_tick,
    input  logic          blink_tick,
    input  logic          mode_btn,
    input  logic          inc_btn,
    output logic [TW-1:0] H,
    output logic [TW-1:0] M,
    output logic [TW-1:0] S,
    output logic [1:0]    set_mode,
    output logic          blank_h,
    output logic          blank_m
);
    logic          mode_ev, inc_ev;
    state_t        state, state_nx;
    logic          blink_phase, phase_nx;
    logic          inc_applied;
    logic [TW-1:0] h_nx, m_nx, s_nx;

    btn_edge u_mode_edge (.clk(clk), .rst(rst), .btn(mode_btn), .ev(mode_ev));
    btn_edge u_inc_edge  (.clk(clk), .rst(rst), .btn(inc_btn),  .ev(inc_ev));

    always_comb begin
        state_nx    = state;
        h_nx        = H;
        m_nx        = M;
        s_nx        = S;
        inc_applied = 1'b0;
        case (state)
            RUN: begin
                if (sec_tick) begin
                    s_nx = wrap_inc(S, S_MOD);
                    if (int'(S) == S_MOD - 1) begin
                        m_nx = wrap_inc(M, M_MOD);
                        if (int'(M) == M_MOD - 1)
                            h_nx = wrap_inc(H, H_MOD);
                    end
                end
                if (mode_ev)
                    state_nx = SET_H;
            end
            SET_H: begin
                if (mode_ev) begin
                    state_nx = SET_M;
                end else if (inc_ev) begin
                    h_nx        = wrap_inc(H, H_MOD);
                    inc_applied = 1'b1;
                end
            end
            SET_M: begin
                // Leaving the editor restarts counting on a whole minute.
                if (mode_ev) begin
                    state_nx = RUN;
                    s_nx     = '0;
                end else if (inc_ev) begin
                    m_nx        = wrap_inc(M, M_MOD);
                    inc_applied = 1'b1;
                end
            end
            default: state_nx = RUN;
        endcase

        // Edited field is shown solid right after any press or mode change.
        if (state_nx != state || inc_applied)
            phase_nx = 1'b0;
        else if (blink_tick)
            phase_nx = ~blink_phase;
        else
            phase_nx = blink_phase;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            H           <= '0;
            M           <= '0;
            S           <= '0;
            blink_phase <= 1'b0;
            blank_h     <= 1'b0;
            blank_m     <= 1'b0;
        end else begin
            state       <= state_nx;
            H           <= h_nx;
            M           <= m_nx;
            S           <= s_nx;
            blink_phase <= phase_nx;
            blank_h     <= (state_nx == SET_H) && phase_nx;
            blank_m     <= (state_nx == SET_M) && phase_nx;
        end
    end

    assign set_mode = state;

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Time-keeping and time-setting controller for the HH:MM:SS seven-segment clock.
- Owns the H/M/S registers and advances them on a 1 Hz enable pulse.
- Sequences a user set mode from two push-buttons: RUN -> SET_H -> SET_M -> RUN.
- Outputs feed the existing binary-to-BCD split and seven-segment decoders unchanged, plus per-field blank flags that blink the field being edited.

Parameters:
- H_MOD, 24, hour modulus (hours count 0..H_MOD-1)
- M_MOD, 60, minute modulus
- S_MOD, 60, second modulus

Ports:
- clk  input  1  system clock; all logic in this domain
- rst  input  1  synchronous, active-high reset
- sec_tick  input  1  one-cycle enable pulse, once per second, clk domain
- blink_tick  input  1  one-cycle enable pulse, about 2 Hz, clk domain
- mode_btn  input  1  raw mode button level, already debounced, asynchronous
- inc_btn  input  1  raw increment button level, already debounced, asynchronous
- H  output  7  hours, binary, 0..H_MOD-1
- M  output  7  minutes, binary, 0..M_MOD-1
- S  output  7  seconds, binary, 0..S_MOD-1
- set_mode  output  2  current state: 0 RUN, 1 SET_H, 2 SET_M
- blank_h  output  1  1 = blank both hour digits this cycle
- blank_m  output  1  1 = blank both minute digits this cycle

Behaviour:
- Reset (rst=1 at a clk edge): H=M=S=0, state RUN, set_mode=0, blank_h=blank_m=0, blink_phase=0, all synchroniser and edge flops=0. Reset mid-edit returns to RUN with time cleared.
- Button path:
  - Two-flop synchroniser, then rising-edge detect, gives a one-cycle event (mode_ev, inc_ev).
  - A level change at the button input shows up as a register update 3 clk edges later.
  - A held button generates exactly one event; there is no auto-repeat.
- FSM:
  - RUN: mode_ev -> SET_H.
  - SET_H: mode_ev -> SET_M.
  - SET_M: mode_ev -> RUN.
  - Encoding 2'b11 is illegal and recovers to RUN on the next edge.
- RUN:
  - sec_tick increments S.
  - S=S_MOD-1 wraps to 0 and carries into M; M=M_MOD-1 wraps and carries into H; H=H_MOD-1 wraps to 0.
  - 23:59:59 + tick = 00:00:00.
  - Updates are registered: outputs change on the edge that samples sec_tick.
  - inc_ev is ignored.
- SET_H:
  - Time is frozen; sec_tick is ignored.
  - inc_ev sets H=(H+1) mod H_MOD; M and S are unchanged.
- SET_M:
  - Time is frozen.
  - inc_ev sets M=(M+1) mod M_MOD with no carry into H.
- Exit from SET_M to RUN: S is cleared to 0 on the transition edge, so counting restarts from a whole minute.
- Simultaneous events:
  - mode_ev and inc_ev in the same cycle: mode_ev wins and inc_ev is dropped.
  - sec_tick and mode_ev in RUN in the same cycle: the tick is applied and the state moves to SET_H on the same edge.
- Blink:
  - blink_phase toggles on each blink_tick.
  - blink_phase is forced to 0 on every state transition and on every applied inc_ev, so the edited field is visible immediately after a press.
  - blank_h = (state==SET_H) & blink_phase; blank_m = (state==SET_M) & blink_phase. Both are registered.
  - In RUN both flags are 0.
- Output ranges: H, M and S never leave their modulus range. The upper bits of the 7-bit outputs are zero-filled.

Decomposition:
- Shared package clock_pkg:
  - state type with RUN/SET_H/SET_M encodings
  - field width constant TW=7
  - default moduli 24/60/60
- Sub-module btn_edge (2-flop sync + rising-edge pulse, clk/rst): instantiated twice, once for mode_btn and once for inc_btn.
- FSM, time registers and blink logic stay in clock_set_ctrl.

Test Plan:
- Reset, then 3661 sec_tick pulses -> H=1, M=1, S=1, set_mode=0, blank_h=blank_m=0.
- Preload 23:59:58 via the set sequence plus ticks; 2 more sec_ticks -> 23:59:59 then 00:00:00.
- Press mode once -> set_mode=1 on the 3rd edge after the press. 30 sec_ticks -> S unchanged. 25 inc presses from H=0 -> H=1 (wrap at 24).
- In SET_M at M=59, one inc press -> M=0 and H unchanged. Mode press -> set_mode=0 and S=0 on the same edge.
- Hold inc_btn high for 1000 cycles in SET_H -> exactly one increment.
- In SET_H, 4 blink_ticks -> blank_h toggles 1,0,1,0. inc press -> blank_h=0 immediately. mode_btn and inc_btn rising on the same cycle -> state advances and no increment occurs.
- Assert rst while in SET_M at 12:34 -> next edge gives 00:00:00, set_mode=0, blank_m=0.
